// File: rtl/io_map_pkg.sv
// Shared constants and address-map helper for the IO-mapped bus decoder.
package io_map_pkg;

    localparam int unsigned DEF_AW   = 8;
    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_N_IO = 1;

    // First address of the IO window; the window occupies the top n_io addresses.
    function automatic int unsigned io_base(input int unsigned aw, input int unsigned n_io);
        return (32'd1 << aw) - n_io;
    endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a bus sampled from an asynchronous domain.
module bit_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_p0;
    logic [W-1:0] sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/io_map_decoder.sv
// Splits a flat bus address space into RAM and N_IO IO channels at the top of the map,
// with a read mux that matches the synchronous RAM's one-cycle read latency.
module io_map_decoder
    import io_map_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int N_IO     = DEF_N_IO,
    parameter int READBACK = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [AW-1:0]        MA,
    input  logic [DW-1:0]        MD_in,
    input  logic [DW-1:0]        ram_rdata,
    input  logic [N_IO*DW-1:0]   io_in,
    output logic                 we_ram,
    output logic [N_IO*DW-1:0]   io_out,
    output logic [N_IO-1:0]      io_strobe,
    output logic [DW-1:0]        rdata
);

    localparam int IW   = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam int NSEL = 1 << IW;
    localparam logic [AW-1:0] BASE = AW'(io_base(AW, N_IO));

    logic          in_io;
    logic [IW-1:0] idx;
    logic          sel_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] out_q   [N_IO];
    logic [DW-1:0] sync_ch [N_IO];
    logic [DW-1:0] rd_src  [NSEL];

    assign in_io  = (MA >= BASE);
    assign idx    = IW'(MA - BASE);
    assign we_ram = we & ~in_io;

    // Address decode stage: register the read select alongside the channel writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= 1'b0;
            idx_q     <= '0;
            io_strobe <= '0;
            for (int c = 0; c < N_IO; c++) out_q[c] <= '0;
        end else begin
            sel_q <= in_io;
            idx_q <= idx;
            for (int c = 0; c < N_IO; c++) begin
                io_strobe[c] <= we && in_io && (idx == IW'(c));
                if (we && in_io && (idx == IW'(c))) out_q[c] <= MD_in;
            end
        end
    end

    for (genvar g = 0; g < N_IO; g++) begin : g_chan
        bit_sync2 #(.W(DW)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (io_in[g*DW +: DW]),
            .q     (sync_ch[g])
        );
        assign io_out[g*DW +: DW] = out_q[g];
    end

    // Pad the source table to a power of two so idx_q never selects past its end
    for (genvar g = 0; g < NSEL; g++) begin : g_src
        if (g < N_IO) begin : g_live
            assign rd_src[g] = (READBACK != 0) ? out_q[g] : sync_ch[g];
        end else begin : g_pad
            assign rd_src[g] = '0;
        end
    end

    assign rdata = sel_q ? rd_src[idx_q] : ram_rdata;

endmodule

// File: tb/tb_io_map_decoder.sv
// Bench for io_map_decoder: three configurations (N_IO=4/READBACK=0, N_IO=4/READBACK=1, N_IO=1).
module tb_io_map_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [7:0]  MA, MD_in, ram_rdata;
    logic [31:0] io_in;

    logic        wr_a, wr_b, wr_c;
    logic [31:0] out_a, out_b;
    logic [7:0]  out_c;
    logic [3:0]  stb_a, stb_b;
    logic [0:0]  stb_c;
    logic [7:0]  rd_a, rd_b, rd_c;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    io_map_decoder #(.AW(8), .DW(8), .N_IO(4), .READBACK(0)) dut_a (
        .clk(clk), .reset(reset), .we(we), .MA(MA), .MD_in(MD_in), .ram_rdata(ram_rdata),
        .io_in(io_in), .we_ram(wr_a), .io_out(out_a), .io_strobe(stb_a), .rdata(rd_a));

    io_map_decoder #(.AW(8), .DW(8), .N_IO(4), .READBACK(1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .MA(MA), .MD_in(MD_in), .ram_rdata(ram_rdata),
        .io_in(io_in), .we_ram(wr_b), .io_out(out_b), .io_strobe(stb_b), .rdata(rd_b));

    io_map_decoder #(.AW(8), .DW(8), .N_IO(1), .READBACK(0)) dut_c (
        .clk(clk), .reset(reset), .we(we), .MA(MA), .MD_in(MD_in), .ram_rdata(ram_rdata),
        .io_in(io_in[7:0]), .we_ram(wr_c), .io_out(out_c), .io_strobe(stb_c), .rdata(rd_c));

    // Reference model: config 0 = dut_a, 1 = dut_b, 2 = dut_c
    int         nio [3] = '{4, 4, 1};
    bit         rbk [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_out [3][4];
    logic [3:0] m_stb [3];
    bit         m_sel [3];
    int         m_idx [3];
    logic [7:0] m_s1 [4];
    logic [7:0] m_s2 [4];

    function automatic bit in_win(int i, logic [7:0] a);
        return int'(a) >= 256 - nio[i];
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 4; c++) m_out[i][c] = 8'h00;
                m_stb[i] = 4'h0;
                m_sel[i] = 1'b0;
                m_idx[i] = 0;
            end
            for (int c = 0; c < 4; c++) begin
                m_s1[c] = 8'h00;
                m_s2[c] = 8'h00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int k;
                bit hit;
                k   = int'(MA) - (256 - nio[i]);
                hit = in_win(i, MA);
                m_stb[i] = 4'h0;
                if (we && hit) begin
                    m_out[i][k] = MD_in;
                    m_stb[i][k] = 1'b1;
                end
                m_sel[i] = hit;
                m_idx[i] = hit ? k : 0;
            end
            for (int c = 0; c < 4; c++) begin
                m_s2[c] = m_s1[c];
                m_s1[c] = io_in[c*8 +: 8];
            end
        end
    endtask

    function automatic logic [7:0] exp_rdata(int i);
        if (!m_sel[i]) return ram_rdata;
        return rbk[i] ? m_out[i][m_idx[i]] : m_s2[m_idx[i]];
    endfunction

    function automatic logic [31:0] exp_out(int i);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < nio[i]; c++) v[c*8 +: 8] = m_out[i][c];
        return v;
    endfunction

    function automatic logic [31:0] got_out(int i);
        case (i)
            0:       return out_a;
            1:       return out_b;
            default: return {24'h0, out_c};
        endcase
    endfunction

    function automatic logic [3:0] got_stb(int i);
        case (i)
            0:       return stb_a;
            1:       return stb_b;
            default: return {3'b000, stb_c};
        endcase
    endfunction

    function automatic logic [7:0] got_rd(int i);
        case (i)
            0:       return rd_a;
            1:       return rd_b;
            default: return rd_c;
        endcase
    endfunction

    function automatic logic got_wr(int i);
        case (i)
            0:       return wr_a;
            1:       return wr_b;
            default: return wr_c;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("io_out[%0d]", i),    got_out(i), exp_out(i));
            chk($sformatf("io_strobe[%0d]", i), 32'(got_stb(i)), 32'(m_stb[i]));
            chk($sformatf("rdata[%0d]", i),     32'(got_rd(i)), 32'(exp_rdata(i)));
        end
    endtask

    // Inputs are set by the caller shortly after an edge; we_ram is checked before the next edge
    task automatic cycle(output logic [2:0] wr);
        #1;
        wr = {wr_c, wr_b, wr_a};
        for (int i = 0; i < 3; i++)
            chk($sformatf("we_ram[%0d]", i), 32'(got_wr(i)), 32'(we && !in_win(i, MA)));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  ma;
        logic [7:0]  md;
        logic        wr_c;
        logic        wr_a;
        logic [31:0] out_a;
        logic [3:0]  stb_a;
        logic [7:0]  out_c;
        logic        stb_c;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [2:0] wr;

        tbl[0]  = '{1'b1, 8'hFC, 8'h11, 1'b1, 1'b0, 32'h00000011, 4'b0001, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'hFD, 8'h22, 1'b1, 1'b0, 32'h00002211, 4'b0010, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'hFE, 8'h33, 1'b1, 1'b0, 32'h00332211, 4'b0100, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'hFF, 8'h44, 1'b0, 1'b0, 32'h44332211, 4'b1000, 8'h44, 1'b1};
        tbl[4]  = '{1'b1, 8'hFB, 8'h99, 1'b1, 1'b1, 32'h44332211, 4'b0000, 8'h44, 1'b0};
        tbl[5]  = '{1'b0, 8'hFF, 8'h55, 1'b0, 1'b0, 32'h44332211, 4'b0000, 8'h44, 1'b0};
        tbl[6]  = '{1'b1, 8'hFF, 8'h66, 1'b0, 1'b0, 32'h66332211, 4'b1000, 8'h66, 1'b1};
        tbl[7]  = '{1'b1, 8'hFF, 8'h77, 1'b0, 1'b0, 32'h77332211, 4'b1000, 8'h77, 1'b1};
        tbl[8]  = '{1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 32'h77332211, 4'b0000, 8'h77, 1'b0};
        tbl[9]  = '{1'b1, 8'hFC, 8'h00, 1'b1, 1'b0, 32'h77332200, 4'b0001, 8'h77, 1'b0};
        tbl[10] = '{1'b1, 8'hFE, 8'hAB, 1'b1, 1'b0, 32'h77AB2200, 4'b0100, 8'h77, 1'b0};
        tbl[11] = '{1'b1, 8'hFF, 8'h5A, 1'b0, 1'b0, 32'h5AAB2200, 4'b1000, 8'h5A, 1'b1};

        reset = 1'b1; we = 1'b0; MA = 8'h00; MD_in = 8'h00; ram_rdata = 8'h3C; io_in = '0;
        cycle(wr);
        cycle(wr);
        chk("reset io_out a", out_a, 32'h0);
        chk("reset io_out c", {24'h0, out_c}, 32'h0);
        chk("reset strobe a", {28'h0, stb_a}, 32'h0);
        chk("reset rdata a", {24'h0, rd_a}, 32'h3C);
        reset = 1'b0;

        // Write map table: io_out / strobe / we_ram for the N_IO=4 and N_IO=1 maps
        for (int r = 0; r < 12; r++) begin
            we = tbl[r].we; MA = tbl[r].ma; MD_in = tbl[r].md; ram_rdata = 8'($urandom);
            cycle(wr);
            chk($sformatf("tbl%0d we_ram a", r), {31'h0, wr[0]}, {31'h0, tbl[r].wr_a});
            chk($sformatf("tbl%0d we_ram c", r), {31'h0, wr[2]}, {31'h0, tbl[r].wr_c});
            chk($sformatf("tbl%0d io_out a", r), out_a, tbl[r].out_a);
            chk($sformatf("tbl%0d io_out b", r), out_b, tbl[r].out_a);
            chk($sformatf("tbl%0d strobe a", r), {28'h0, stb_a}, {28'h0, tbl[r].stb_a});
            chk($sformatf("tbl%0d io_out c", r), {24'h0, out_c}, {24'h0, tbl[r].out_c});
            chk($sformatf("tbl%0d strobe c", r), {31'h0, stb_c}, {31'h0, tbl[r].stb_c});
        end

        // Synchronised IO read, then a RAM read
        we = 1'b0; MA = 8'h10; ram_rdata = 8'h11; io_in = 32'h00A50000;
        cycle(wr);
        cycle(wr);
        MA = 8'hFE;
        cycle(wr);
        chk("io read ch2", {24'h0, rd_a}, 32'hA5);
        MA = 8'h10; ram_rdata = 8'h77;
        cycle(wr);
        chk("ram read", {24'h0, rd_a}, 32'h77);

        // Readback of a just-written channel
        we = 1'b1; MA = 8'hFD; MD_in = 8'hC3;
        cycle(wr);
        we = 1'b0;
        cycle(wr);
        chk("readback ch1", {24'h0, rd_b}, 32'hC3);

        // Synchroniser latency on the single-channel map
        MA = 8'hFF; io_in = 32'h0;
        cycle(wr);
        cycle(wr);
        cycle(wr);
        io_in = 32'h000000FF;
        cycle(wr);
        chk("sync edge1", {24'h0, rd_c}, 32'h00);
        cycle(wr);
        chk("sync edge2", {24'h0, rd_c}, 32'hFF);

        // Reset landing in the middle of a write to 0xFF
        we = 1'b1; MA = 8'hFF; MD_in = 8'h5A; ram_rdata = 8'h3C;
        #3;
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        chk("midwrite io_out c", {24'h0, out_c}, 32'h0);
        chk("midwrite strobe c", {31'h0, stb_c}, 32'h0);
        chk("midwrite rdata c", {24'h0, rd_c}, 32'h3C);
        reset = 1'b0; we = 1'b0; MA = 8'h20;
        cycle(wr);
        chk("post-reset strobe c", {31'h0, stb_c}, 32'h0);
        chk("post-reset io_out c", {24'h0, out_c}, 32'h0);

        // Randomised traffic biased toward the top of the map
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            we        = 1'($urandom_range(0, 1));
            MA        = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            MD_in     = 8'($urandom);
            ram_rdata = 8'($urandom);
            if ($urandom_range(0, 3) == 0) io_in = $urandom;
            cycle(wr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_map_decoder.md
IO_MAP_DECODER -- requirements
Module: io_map_decoder

Interface
REQ-001 Parameter AW, default 8, SHALL set the memory address width in bits.
REQ-002 Parameter DW, default 8, SHALL set the data width in bits.
REQ-003 Parameter N_IO, default 1, range 1..16, SHALL set the number of IO channels mapped at the top N_IO addresses.
REQ-004 Parameter READBACK, default 0, SHALL select the IO read source: 0 = synchronised io_in, 1 = io_out register.
REQ-005 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 we  input  1  SHALL be the bus write enable.
REQ-008 MA  input  AW  SHALL be the memory address.
REQ-009 MD_in  input  DW  SHALL be the bus write data.
REQ-010 ram_rdata  input  DW  SHALL be the synchronous-RAM read data, valid one cycle after MA.
REQ-011 io_in  input  N_IO*DW  SHALL be the external input channels, channel k at bits [k*DW +: DW], asynchronous to clk.
REQ-012 we_ram  output  1  SHALL be the RAM write enable.
REQ-013 io_out  output  N_IO*DW  SHALL be the registered output channels, same packing as io_in.
REQ-014 io_strobe  output  N_IO  SHALL be a one-cycle per-channel write pulse.
REQ-015 rdata  output  DW  SHALL be the bus read data.

Function
REQ-016 IO window: in_io SHALL be 1 iff MA >= 2^AW - N_IO; channel index k = MA - (2^AW - N_IO).
REQ-017 we_ram SHALL be combinational: we & ~in_io; no latency.
REQ-018 On a rising edge with we=1 and in_io=1, io_out[k] SHALL load MD_in; other channels hold.
REQ-019 io_strobe[k] SHALL be 1 for exactly the cycle after the edge that wrote channel k, otherwise 0; back-to-back writes to k SHALL keep it high on consecutive cycles.
REQ-020 Every edge SHALL capture sel_q <= in_io and idx_q <= k, regardless of we.
REQ-021 rdata SHALL be ram_rdata when sel_q=0; when sel_q=1, the IO source of channel idx_q per READBACK; this gives 1-cycle read latency, matching the RAM.
REQ-022 Each io_in channel SHALL pass through a 2-flop synchroniser before the read mux; a change on io_in SHALL be visible on rdata no earlier than 2 edges later.
REQ-023 READBACK=1: a write to channel k followed by a read of k on the next cycle SHALL return the new value.
REQ-024 Address 2^AW - N_IO - 1 SHALL decode as RAM; address 2^AW - 1 SHALL be channel N_IO-1.
REQ-025 N_IO=1, AW=8 SHALL reproduce the legacy single-port map: 0xFF = IO, all other addresses = RAM.
REQ-026 Index arithmetic SHALL be done at AW bits; idx_q SHALL be clog2(N_IO) bits (minimum 1).

Reset
REQ-027 While reset=1: io_out = 0, io_strobe = 0, sel_q = 0, idx_q = 0, synchroniser flops = 0; rdata therefore follows ram_rdata.
REQ-028 Reset asserted mid-write SHALL cancel the write; io_strobe SHALL not pulse after release.
REQ-029 we_ram SHALL stay combinational and unaffected by reset.

Structure
REQ-030 Package io_map_pkg SHALL hold default AW/DW/N_IO constants and a function io_base(AW, N_IO) returning 2^AW - N_IO.
REQ-031 A single sub-module bit_sync2 (parametrised width, 2-flop, async reset to 0) SHALL be instantiated once per channel.

Verification
REQ-032 AW=8, N_IO=1: we=1, MA=0xFE -> we_ram=1, io_out unchanged; we=1, MA=0xFF, MD_in=0x5A -> we_ram=0, io_out=0x5A next cycle, io_strobe=1 for one cycle.
REQ-033 N_IO=4: write 0x11,0x22,0x33,0x44 to 0xFC..0xFF -> io_out=0x44332211; MA=0xFB write -> we_ram=1, io_out unchanged.
REQ-034 READBACK=0, N_IO=4: io_in channel 2 = 0xA5, read MA=0xFE -> rdata=0xA5 one cycle later; read MA=0x10 with ram_rdata=0x77 -> rdata=0x77 one cycle later.
REQ-035 READBACK=1: write 0xC3 to 0xFD, then read 0xFD on the next cycle -> rdata=0xC3.
REQ-036 Toggle io_in 0x00->0xFF -> rdata keeps the old value for the first edge and shows 0xFF after the second.
REQ-037 Assert reset during a write to 0xFF -> io_out=0, io_strobe never pulses, rdata follows ram_rdata.
